// File: rtl/fifo_burst_reader.sv
// Pops FWFT FIFO words into framed bursts: full on progempty drop, partial on timeout/flush/dry FIFO.
// Latency 2 cycles pop->m_valid; m_ready low holds O, then H, then stops popping.
module fifo_burst_reader #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic          fifo_progempty,
    output logic          fifo_rd_en,
    input  logic          flush,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          burst_done
);
    localparam int LW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(BURST_LEN);
    localparam logic [LW-1:0] LEN_LAST = LW'(BURST_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FULL, S_PART, S_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [LW-1:0] popped, sent;
    logic          h_valid;
    logic [DW-1:0] h_data;
    logic          in_burst, o_free, mv, pop, last_bit, start;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_progempty)                         state_nxt = S_FULL;
                else if (flush && !fifo_empty)               state_nxt = S_PART;
                else if (timer == TMO_LAST && !fifo_empty)   state_nxt = S_PART;
            end
            S_FULL, S_PART: if (mv && last_bit) state_nxt = S_DRAIN;
            S_DRAIN:        if (m_valid && m_ready) state_nxt = S_IDLE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // An empty FIFO only ends a partial burst; in FULL it is a stall, never an early last.
    always_comb begin
        in_burst   = (state == S_FULL) || (state == S_PART);
        o_free     = !m_valid || m_ready;
        mv         = in_burst && h_valid && o_free;
        last_bit   = (sent == LEN_LAST) || ((state == S_PART) && fifo_empty);
        pop        = in_burst && rst_n && !fifo_empty && (!h_valid || mv)
                     && (popped < LEN_MAX) && !(mv && last_bit);
        fifo_rd_en = pop;
        start      = (state == S_IDLE) && (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer      <= '0;
            popped     <= '0;
            sent       <= '0;
            h_valid    <= 1'b0;
            h_data     <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            if (state == S_IDLE && state_nxt == S_IDLE)
                timer <= fifo_empty ? '0 : timer + TW'(1);
            else
                timer <= '0;

            if (start) begin
                popped <= '0;
                sent   <= '0;
            end else begin
                if (pop && popped < LEN_MAX) popped <= popped + LW'(1);
                if (mv && sent < LEN_MAX)    sent   <= sent + LW'(1);
            end

            if (pop) begin
                h_data  <= fifo_dout;
                h_valid <= 1'b1;
            end else if (mv) begin
                h_valid <= 1'b0;
            end

            if (mv) begin
                m_data  <= h_data;
                m_last  <= last_bit;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            busy       <= (state_nxt != S_IDLE);
            burst_done <= (state == S_DRAIN) && m_valid && m_ready;
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model + burst-framing reference model feeding a scoreboard.
module tb_fifo_burst_reader;
    localparam int DW  = 8;
    localparam int BL  = 4;
    localparam int TMO = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty, fifo_progempty, fifo_rd_en;
    logic          flush = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, busy, burst_done;
    logic          m_ready;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;

    logic [DW-1:0] mem [0:1023];
    logic [15:0]   wr_ptr = '0;
    logic [15:0]   rd_ptr = '0;
    logic [15:0]   fill;
    beat_t         exp_q[$];

    always #5 clk = ~clk;

    assign fill           = wr_ptr - rd_ptr;
    assign fifo_empty     = (fill == 16'd0);
    assign fifo_dout      = mem[rd_ptr[9:0]];
    assign fifo_progempty = (fill < 16'(BL));

    fifo_burst_reader #(.DW(DW), .BURST_LEN(BL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_progempty(fifo_progempty),
        .fifo_rd_en(fifo_rd_en), .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .burst_done(burst_done)
    );

    // FIFO read side: a pop is only legal on a non-empty FIFO outside reset
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            total++;
            if (fifo_empty || !rst_n) begin
                bad++;
                $display("FAIL illegal_pop: empty=%0b rst_n=%0b, required empty=0 rst_n=1", fifo_empty, rst_n);
            end
            rd_ptr <= rd_ptr + 16'd1;
        end
    end

    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph == 0);
                    ph = (ph == 2) ? 0 : ph + 1;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on handshake, hold rule under stall, burst_done after a last beat
    logic          prev_stall = 1'b0;
    logic          prev_lhs   = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    always begin
        beat_t e;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_lhs   = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (!m_valid || m_data !== prev_d || m_last !== prev_l) begin
                    bad++;
                    $display("FAIL hold: got v=%0b d=%0h l=%0b, required v=1 d=%0h l=%0b",
                             m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            if (prev_lhs || burst_done) begin
                total++;
                if (burst_done !== prev_lhs) begin
                    bad++;
                    $display("FAIL burst_done: got %0b, required %0b", burst_done, prev_lhs);
                end
            end
            if (m_valid && m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat: got d=%0h l=%0b, required no beat", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        bad++;
                        $display("FAIL beat: got d=%0h l=%0b, required d=%0h l=%0b", m_data, m_last, e.d, e.l);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
            prev_lhs   = m_valid && m_ready && m_last;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr[9:0]] = d;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    // Reference: n words loaded at once into an empty FIFO leave as BL-word bursts,
    // the remainder as one partial burst; last on every BL-th word and on the final word.
    task automatic load_burst(input int n, input int base, input bit rnd);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? DW'($urandom) : DW'(base + i);
            push_word(d);
            expect_beat(d, ((i % BL) == BL - 1) || (i == n - 1));
        end
    endtask

    task automatic trace(input int n, output logic [31:0] rd, output logic [31:0] vv,
                         output logic [31:0] ll, output logic [31:0] bd, output logic [31:0] bz);
        rd = '0; vv = '0; ll = '0; bd = '0; bz = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            rd[i] = fifo_rd_en;
            vv[i] = m_valid;
            ll[i] = m_valid && m_last;
            bd[i] = burst_done;
            bz[i] = busy;
            if (i == 0) flush = 1'b0;
        end
    endtask

    task automatic wait_done(input string nm);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 800 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && fifo_empty) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: pending=%0d busy=%0b, required drained", nm, exp_q.size(), busy);
        end
    endtask

    initial begin
        logic [31:0] rd, vv, ll, bd, bz;
        int nrd, nb, nt, n;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_burst_done", 32'(burst_done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two back-to-back full bursts
        load_burst(8, 'h10, 1'b0);
        trace(16, rd, vv, ll, bd, bz);
        chk("full_rd_en", rd, 32'h078F);
        chk("full_valid", vv, 32'h1E3C);
        chk("full_last", ll, 32'h1020);
        chk("full_done", bd, 32'h2040);
        chk("full_busy", bz, 32'h1FBF);
        wait_done("full");

        // Timeout partial burst
        load_burst(2, 'hA0, 1'b0);
        trace(16, rd, vv, ll, bd, bz);
        chk("tmo_rd_en", rd, 32'h0180);
        chk("tmo_valid", vv, 32'h0600);
        chk("tmo_last", ll, 32'h0400);
        chk("tmo_done", bd, 32'h0800);
        chk("tmo_busy", bz, 32'h0780);
        wait_done("tmo");

        // Full bursts under a 1,0,0 ready pattern
        rdy_mode = 1;
        load_burst(8, 'h10, 1'b0);
        wait_done("stall");
        rdy_mode = 0;
        @(negedge clk);

        // Flush pulse with a single word
        flush = 1'b1;
        load_burst(1, 'h55, 1'b0);
        trace(8, rd, vv, ll, bd, bz);
        chk("flush_rd_en", rd, 32'h01);
        chk("flush_valid", vv, 32'h04);
        chk("flush_last", ll, 32'h04);
        chk("flush_done", bd, 32'h08);
        chk("flush_busy", bz, 32'h07);
        wait_done("flush");

        // Reset after the second beat drops the two words held in H and O
        for (int i = 0; i < 8; i++) push_word(DW'('h20 + i));
        expect_beat(8'h20, 1'b0);
        expect_beat(8'h21, 1'b0);
        for (int i = 4; i < 8; i++) expect_beat(DW'('h20 + i), i == 7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(burst_done), 32'd0);
        wait_done("midrst");

        // Empty FIFO: nothing happens
        nrd = 0; nb = 0; nt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en) nrd++;
            if (busy) nb++;
            if (dut.timer != '0) nt++;
        end
        chk("empty_rd_en_cycles", 32'(nrd), 32'd0);
        chk("empty_busy_cycles", 32'(nb), 32'd0);
        chk("empty_timer_cycles", 32'(nt), 32'd0);

        // Randomized loads, ready patterns and flush pulses
        for (int it = 0; it < 9; it++) begin
            @(negedge clk);
            rdy_mode = it % 3;
            n = int'($urandom_range(1, 11));
            if ($urandom_range(0, 1) == 1) flush = 1'b1;
            load_burst(n, 0, 1'b1);
            @(negedge clk);
            flush = 1'b0;
            wait_done("rand");
        end
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
